// File: rtl/lfsr_pkg.sv
// Shared constants and the reference step function for the serial LFSR.
// The step function is written for any width up to 64 so the same helper
// serves every parameterisation of lfsr_serial.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH_DEF = 11;
  // x^11 + x^9 + 1 : taps on state bits 10 and 8 (maximal length, period 2047)
  localparam logic [10:0] LFSR_POLY_DEF = 11'b10100000000;
  localparam logic [10:0] LFSR_SEED_DEF = 11'b11011011011;

  // One Fibonacci step: shift left, XOR of the tapped bits enters at the LSB.
  // Bits above 'width' are cleared so narrower registers can share the helper.
  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] poly,
                                            input int unsigned width);
    logic [63:0] mask;
    logic        fb;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    fb   = ^(state & poly & mask);
    return ((state << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_serial_if.sv
// Control/data bundle of the serial LFSR: load and step commands in,
// serial bit out. The master side drives commands, the slave is the LFSR.
interface lfsr_serial_if;

  logic ld;
  logic en;
  logic dout;

  modport master (output ld, output en, input dout);
  modport slave  (input ld, input en, output dout);

endinterface

// File: rtl/lfsr_serial.sv
// Fibonacci LFSR with a registered one-bit serial output.
// The seed is taken only when a load coincides with a step enable; dout is
// the state MSB delayed by one clock and is refreshed on every edge, so a
// frozen register shows a constant bit. An all-zero state is a lock-up state
// left only by a load.
module lfsr_serial
  import lfsr_pkg::*;
#(
  parameter int unsigned               LFSR_WIDTH      = LFSR_WIDTH_DEF,
  parameter logic [LFSR_WIDTH-1:0]     LFSR_POLYNOMIAL = LFSR_POLY_DEF,
  parameter logic [LFSR_WIDTH-1:0]     LFSR_SEED       = LFSR_SEED_DEF
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_serial_if.slave  bus
);

  // Reject parameter sets that cannot produce a useful sequence.
  if (LFSR_WIDTH < 2) begin : g_bad_width
    $error("lfsr_serial: LFSR_WIDTH must be at least 2");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("lfsr_serial: LFSR_SEED must be non-zero");
  end
  if (LFSR_POLYNOMIAL[LFSR_WIDTH-1] == 1'b0) begin : g_bad_poly
    $error("lfsr_serial: LFSR_POLYNOMIAL needs the MSB tap set");
  end

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;
  logic                  fb;
  logic                  dout_q;

  // Feedback bit and next-state selection (load beats step; en gates both).
  always_comb begin
    fb      = ^(state_q & LFSR_POLYNOMIAL);
    state_d = state_q;
    if (bus.en) begin
      if (bus.ld) begin
        state_d = LFSR_SEED;
      end else begin
        state_d = {state_q[LFSR_WIDTH-2:0], fb};
      end
    end
  end

  // State and output registers; synchronous reset overrides load and step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= state_q[LFSR_WIDTH-1];
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_lfsr_serial.sv
module tb_lfsr_serial;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  lfsr_serial_if bus ();

  lfsr_serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        en;
    logic        exp_dout;
    logic [10:0] exp_state;
  } vec_t;

  vec_t vecs[19];

  task automatic drive(input logic r, input logic l, input logic e);
    reset  = r;
    bus.ld = l;
    bus.en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic check_state(input string nm, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  initial begin
    logic [63:0] m;
    logic        exp_d;
    logic        early;

    reset  = 1'b1;
    bus.ld = 1'b0;
    bus.en = 1'b0;

    //            rst   ld    en    dout  state
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 11'b00000000000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 11'b00000000000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 11'b00000000000};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 11'b00000000000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 11'b11011011011};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 11'b10110110111};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 11'b01101101110};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 11'b11011011101};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 11'b11011011101};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 11'b11011011101};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 11'b11011011101};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 11'b11011011101};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'b10110111011};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'b01101110110};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'b11011101101};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 11'b11011011011};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'b10110110111};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'b01101101110};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'b11011011101};

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].en);
      check_bit($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      check_state($sformatf("vec%0d_state", i), dut.state_q, vecs[i].exp_state);
    end

    // Reset in mid-stream, then reload: the stream must restart identically.
    for (int run = 0; run < 2; run++) begin
      drive(1'b0, 1'b1, 1'b1);
      check_state($sformatf("run%0d_load", run), dut.state_q, LFSR_SEED_DEF);
      m = 64'(LFSR_SEED_DEF);
      for (int k = 0; k < 10; k++) begin
        drive(1'b0, 1'b0, 1'b1);
        exp_d = m[10];
        m     = lfsr_next(m, 64'(LFSR_POLY_DEF), LFSR_WIDTH_DEF);
        check_bit($sformatf("run%0d_dout%0d", run, k), bus.dout, exp_d);
        check_state($sformatf("run%0d_state%0d", run, k), dut.state_q, m[10:0]);
      end
      drive(1'b1, 1'b0, 1'b1);
      check_bit($sformatf("run%0d_rst_dout", run), bus.dout, 1'b0);
      check_state($sformatf("run%0d_rst_state", run), dut.state_q, 11'd0);
    end

    // First bit after a load from the zero state is the old MSB (0), then seed MSB.
    drive(1'b0, 1'b1, 1'b1);
    check_bit("load_from_zero_dout", bus.dout, 1'b0);

    // Full period against the reference step function.
    m     = 64'(LFSR_SEED_DEF);
    early = 1'b0;
    for (int k = 1; k <= 2047; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      exp_d = m[10];
      m     = lfsr_next(m, 64'(LFSR_POLY_DEF), LFSR_WIDTH_DEF);
      check_bit($sformatf("per_dout%0d", k), bus.dout, exp_d);
      check_state($sformatf("per_state%0d", k), dut.state_q, m[10:0]);
      if (k < 2047) begin
        total++;
        if (dut.state_q === LFSR_SEED_DEF) begin
          bad++;
          if (!early) $display("FAIL per_early_repeat: got seed at step %0d want none before 2047", k);
          early = 1'b1;
        end
      end
    end
    check_state("per_final", dut.state_q, LFSR_SEED_DEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
